// File: rtl/k_means_accumulation.sv
// k_means_accumulation: per-cluster, per-dimension 64-bit sums and point counts, drained cluster-major into the divider.
// Optional K_MEANS_ACCUM_DEBUG_EN adds k_means_accumulation_debug_cnt (accepted in-range points).
module k_means_accumulation #(
  parameter int NUM_CLUSTER   = 8,
  parameter int MAX_DIM_DEPTH = 16,
  parameter int MAX_DIM_WIDTH = 32,
  parameter int CLUSTER_BITS  = $clog2(NUM_CLUSTER),
  parameter int DIM_BITS      = $clog2(MAX_DIM_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_operator,
  input  logic [CLUSTER_BITS:0]    num_cluster,
  input  logic [DIM_BITS:0]        data_dim,
  input  logic [MAX_DIM_WIDTH-1:0] data_in,
  input  logic [CLUSTER_BITS-1:0]  data_cluster,
  input  logic                     data_valid,
  input  logic                     data_last_dim,
  input  logic                     data_last,
  output logic                     data_ready,
  output logic [63:0]              div_sum,
  output logic [63:0]              div_count,
  output logic                     div_valid,
  output logic                     div_last_dim,
  output logic                     div_last,
  output logic                     acc_done
`ifdef K_MEANS_ACCUM_DEBUG_EN
  ,
  output logic [31:0]              k_means_accumulation_debug_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;
  localparam logic [CLUSTER_BITS:0] NC_MAX = (CLUSTER_BITS+1)'(NUM_CLUSTER);
  localparam logic [DIM_BITS:0]     ND_MAX = (DIM_BITS+1)'(MAX_DIM_DEPTH);
  localparam logic [CLUSTER_BITS:0] ONE_C  = (CLUSTER_BITS+1)'(1);
  localparam logic [DIM_BITS:0]     ONE_D  = (DIM_BITS+1)'(1);
  state_t                  state_q, state_d;
  logic [CLUSTER_BITS:0]   ncl_q, ncl_d;
  logic [DIM_BITS:0]       ndim_q, ndim_d;
  logic [DIM_BITS-1:0]     dim_q, dim_d;
  logic [CLUSTER_BITS-1:0] k_q, k_d;
  logic [63:0]             sum_q [NUM_CLUSTER][MAX_DIM_DEPTH];
  logic [63:0]             cnt_q [NUM_CLUSTER];
  logic [63:0]             div_sum_d, div_count_d;
  logic                    div_valid_d, div_last_dim_d, div_last_d, acc_done_d;
  logic                    acc, in_rng, last_d, last_k;
  assign data_ready = state_q == ACCUM;
  // a restart in the same cycle wins over the beat
  assign acc    = data_valid && data_ready && !start_operator;
  assign in_rng = {1'b0, data_cluster} < ncl_q;
  assign last_d = {1'b0, dim_q} == ndim_q - ONE_D;
  assign last_k = {1'b0, k_q} == ncl_q - ONE_C;
  always_comb begin
    state_d        = state_q;
    ncl_d          = ncl_q;
    ndim_d         = ndim_q;
    dim_d          = dim_q;
    k_d            = k_q;
    div_valid_d    = 1'b0;
    div_sum_d      = '0;
    div_count_d    = '0;
    div_last_dim_d = 1'b0;
    div_last_d     = 1'b0;
    acc_done_d     = !start_operator && state_q == DONE;
    if (start_operator) begin
      state_d = ACCUM;
      ncl_d   = num_cluster == '0 ? ONE_C : num_cluster > NC_MAX ? NC_MAX : num_cluster;
      ndim_d  = data_dim == '0 ? ONE_D : data_dim > ND_MAX ? ND_MAX : data_dim;
      dim_d   = '0;
      k_d     = '0;
    end else if (state_q == ACCUM) begin
      if (acc) begin
        dim_d   = data_last_dim || last_d ? '0 : dim_q + DIM_BITS'(1);
        state_d = data_last_dim && data_last ? DRAIN : ACCUM;
      end
    end else if (state_q == DRAIN) begin
      div_valid_d    = 1'b1;
      div_sum_d      = sum_q[k_q][dim_q];
      div_count_d    = cnt_q[k_q];
      div_last_dim_d = last_d;
      div_last_d     = last_d && last_k;
      dim_d          = last_d ? '0 : dim_q + DIM_BITS'(1);
      k_d            = last_d ? k_q + CLUSTER_BITS'(1) : k_q;
      state_d        = last_d && last_k ? DONE : DRAIN;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ncl_q        <= '0;
      ndim_q       <= '0;
      dim_q        <= '0;
      k_q          <= '0;
      div_valid    <= 1'b0;
      div_sum      <= '0;
      div_count    <= '0;
      div_last_dim <= 1'b0;
      div_last     <= 1'b0;
      acc_done     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ncl_q        <= ncl_d;
      ndim_q       <= ndim_d;
      dim_q        <= dim_d;
      k_q          <= k_d;
      div_valid    <= div_valid_d;
      div_sum      <= div_sum_d;
      div_count    <= div_count_d;
      div_last_dim <= div_last_dim_d;
      div_last     <= div_last_d;
      acc_done     <= acc_done_d;
    end
  end
  // out-of-range cluster IDs are consumed without touching any accumulator
  always_ff @(posedge clk) begin
    if (rst || start_operator) begin
      for (int i = 0; i < NUM_CLUSTER; i++) begin
        cnt_q[i] <= '0;
        for (int j = 0; j < MAX_DIM_DEPTH; j++) sum_q[i][j] <= '0;
      end
    end else if (acc && in_rng) begin
      sum_q[data_cluster][dim_q] <= sum_q[data_cluster][dim_q] + 64'(data_in);
      if (data_last_dim) cnt_q[data_cluster] <= cnt_q[data_cluster] + 64'd1;
    end
  end
`ifdef K_MEANS_ACCUM_DEBUG_EN
  logic [31:0] dbg_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_q                          <= '0;
      k_means_accumulation_debug_cnt <= '0;
    end else begin
      dbg_q                          <= start_operator ? '0 : dbg_q + 32'(acc && in_rng && data_last_dim);
      k_means_accumulation_debug_cnt <= dbg_q;
    end
  end
`endif
endmodule

// File: tb/tb_k_means_accumulation.sv
// tb_k_means_accumulation: directed stimulus against a per-cycle drain schedule built from an arithmetic model.
module tb_k_means_accumulation;
  logic        clk = 0, rst = 1, start_operator = 0;
  logic [3:0]  num_cluster = 0;
  logic [4:0]  data_dim = 0;
  logic [31:0] data_in = 0;
  logic [2:0]  data_cluster = 0;
  logic        data_valid = 0, data_last_dim = 0, data_last = 0;
  logic        data_ready, div_valid, div_last_dim, div_last, acc_done;
  logic [63:0] div_sum, div_count;
  k_means_accumulation dut (
    .clk(clk), .rst(rst), .start_operator(start_operator), .num_cluster(num_cluster),
    .data_dim(data_dim), .data_in(data_in), .data_cluster(data_cluster), .data_valid(data_valid),
    .data_last_dim(data_last_dim), .data_last(data_last), .data_ready(data_ready),
    .div_sum(div_sum), .div_count(div_count), .div_valid(div_valid),
    .div_last_dim(div_last_dim), .div_last(div_last), .acc_done(acc_done)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [63:0] s; logic [63:0] c; logic ld; logic l;} beat_t;
  beat_t       exp_b [int];
  bit          exp_done [int];
  beat_t       cap [$];
  beat_t       e;
  logic        ev, ed;
  int          cyc = 0, n_chk = 0, n_pass = 0;
  bit          chk_on = 0;
  logic [63:0] m_sum [8][16];
  logic [63:0] m_cnt [8];
  int          m_ncl = 1, m_ndim = 1, m_dim = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask
  always @(negedge clk) if (chk_on) begin
    ev = exp_b.exists(cyc) != 0;
    e  = ev ? exp_b[cyc] : '0;
    ed = exp_done.exists(cyc) != 0;
    chk("drain_cycle", 136'({div_valid, div_last_dim, div_last, acc_done, div_sum, div_count}),
        136'({ev, e.ld, e.l, ed, e.s, e.c}));
    if (div_valid) cap.push_back({div_sum, div_count, div_last_dim, div_last});
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) step();
  endtask
  task automatic purge(input int t);
    int ks[$];
    foreach (exp_b[k]) if (k > t) ks.push_back(k);
    foreach (ks[i]) exp_b.delete(ks[i]);
    ks.delete();
    foreach (exp_done[k]) if (k > t) ks.push_back(k);
    foreach (ks[i]) exp_done.delete(ks[i]);
  endtask
  task automatic sched(input int t);
    int i = 0;
    for (int k = 0; k < m_ncl; k++)
      for (int d = 0; d < m_ndim; d++) begin
        exp_b[t+2+i] = '{s: m_sum[k][d], c: m_cnt[k], ld: (d == m_ndim-1), l: (d == m_ndim-1 && k == m_ncl-1)};
        i++;
      end
    exp_done[t+2+i] = 1'b1;
  endtask
  task automatic start(input int nc, input int nd);
    start_operator = 1;
    num_cluster    = 4'(nc);
    data_dim       = 5'(nd);
    m_ncl  = nc == 0 ? 1 : nc > 8 ? 8 : nc;
    m_ndim = nd == 0 ? 1 : nd > 16 ? 16 : nd;
    m_dim  = 0;
    for (int k = 0; k < 8; k++) begin
      m_cnt[k] = 0;
      for (int d = 0; d < 16; d++) m_sum[k][d] = 0;
    end
    purge(cyc);
    step();
    start_operator = 0;
  endtask
  task automatic beat(input int c, input logic [31:0] v, input bit ld, input bit l);
    data_valid = 1; data_cluster = 3'(c); data_in = v; data_last_dim = ld; data_last = l;
    chk("data_ready", 136'(data_ready), 136'(1));
    if (c < m_ncl) begin
      m_sum[c][m_dim] += 64'(v);
      if (ld) m_cnt[c] += 64'd1;
    end
    m_dim = (ld || m_dim == m_ndim-1) ? 0 : m_dim + 1;
    if (ld && l) sched(cyc);
    step();
    data_valid = 0; data_last_dim = 0; data_last = 0;
  endtask
  task automatic lit(input string name, input int idx, input logic [63:0] s, input logic [63:0] c, input bit ld, input bit l);
    if (idx < cap.size()) chk(name, 136'(cap[idx]), 136'({s, c, ld, l}));
    else chk({name, "_missing"}, 136'(cap.size()), 136'(idx + 1));
  endtask
  initial begin
    idle(3);
    rst = 0;
    chk_on = 1;
    chk("reset_outputs", 136'({data_ready, div_valid, div_last_dim, div_last, acc_done, div_sum, div_count}), 136'(0));
    // two clusters, two dims
    cap.delete();
    start(2, 2);
    beat(0, 1, 0, 0); beat(0, 2, 1, 0);
    beat(1, 10, 0, 0); beat(1, 20, 1, 0);
    beat(0, 3, 0, 0); beat(0, 4, 1, 1);
    idle(8);
    chk("t1_beats", 136'(cap.size()), 136'(4));
    lit("t1_b0", 0, 4, 2, 0, 0); lit("t1_b1", 1, 6, 2, 1, 0);
    lit("t1_b2", 2, 10, 1, 0, 0); lit("t1_b3", 3, 20, 1, 1, 1);
    // empty clusters, valid held high during drain must be ignored
    cap.delete();
    start(3, 1);
    beat(0, 7, 1, 0); beat(0, 8, 1, 1);
    data_valid = 1; data_cluster = 2; data_in = 99; data_last_dim = 1; data_last = 1;
    idle(5);
    data_valid = 0; data_last_dim = 0; data_last = 0;
    idle(4);
    chk("t2_beats", 136'(cap.size()), 136'(3));
    lit("t2_b0", 0, 15, 2, 1, 0); lit("t2_b1", 1, 0, 0, 1, 0); lit("t2_b2", 2, 0, 0, 1, 1);
    // restart after the first drain beat
    start(2, 2);
    beat(0, 100, 0, 0); beat(0, 200, 1, 1);
    step();
    start(2, 2);
    cap.delete();
    beat(0, 5, 0, 0); beat(0, 7, 1, 1);
    idle(8);
    chk("t3_beats", 136'(cap.size()), 136'(4));
    lit("t3_b0", 0, 5, 1, 0, 0); lit("t3_b1", 1, 7, 1, 1, 0);
    lit("t3_b2", 2, 0, 0, 0, 0); lit("t3_b3", 3, 0, 0, 1, 1);
    // out-of-range cluster ID is discarded
    cap.delete();
    start(4, 1);
    beat(5, 100, 1, 0); beat(1, 3, 1, 1);
    idle(8);
    chk("t4_beats", 136'(cap.size()), 136'(4));
    lit("t4_b0", 0, 0, 0, 1, 0); lit("t4_b1", 1, 3, 1, 1, 0); lit("t4_b3", 3, 0, 0, 1, 1);
    // num_cluster 0 clamps to 1; dim index wraps without last_dim
    cap.delete();
    start(0, 2);
    beat(0, 1, 0, 0); beat(0, 2, 0, 0); beat(0, 3, 0, 0); beat(0, 4, 1, 1);
    idle(6);
    chk("t5_beats", 136'(cap.size()), 136'(2));
    lit("t5_b0", 0, 4, 1, 0, 0); lit("t5_b1", 1, 6, 1, 1, 1);
    // upper clamps: 12 -> 8 clusters, 31 -> 16 dims
    cap.delete();
    start(12, 31);
    for (int d = 0; d < 16; d++) beat(7, 32'(d + 1), d == 15, d == 15);
    idle(135);
    chk("t6_beats", 136'(cap.size()), 136'(128));
    lit("t6_b0", 0, 0, 0, 0, 0); lit("t6_b112", 112, 1, 1, 0, 0); lit("t6_b127", 127, 16, 1, 1, 1);
    // reset mid-accumulation
    start(2, 2);
    beat(0, 50, 0, 0);
    rst = 1;
    purge(cyc);
    step();
    rst = 0;
    chk("rst_mid_outputs", 136'({data_ready, div_valid, div_last_dim, div_last, acc_done, div_sum, div_count}), 136'(0));
    cap.delete();
    start(2, 2);
    beat(0, 1, 0, 0); beat(0, 2, 1, 1);
    idle(8);
    chk("t7_beats", 136'(cap.size()), 136'(4));
    lit("t7_b0", 0, 1, 1, 0, 0); lit("t7_b1", 1, 2, 1, 1, 0); lit("t7_b3", 3, 0, 0, 1, 1);
    chk_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
